// File: rtl/comparador_sequencia.sv
// Sequence checker: compares each player value against consecutive memory words.
// Ports: clock/reset, iniciar/jogada strobes, chaves value, memory port, result flags, debug taps.
module comparador_sequencia #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 5000,
    localparam int ADDR_W = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              jogada,
    input  logic [WIDTH-1:0]  chaves,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WIDTH-1:0]  mem_dado,
    output logic              pronto,
    output logic              acertou,
    output logic              errou,
    output logic              timeout,
    output logic [ADDR_W-1:0] db_contagem,
    output logic [WIDTH-1:0]  db_chaves,
    output logic [WIDTH-1:0]  db_memoria,
    output logic              db_igual,
    output logic [3:0]        db_estado
);

    localparam int TIMER_W = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [3:0] S_INICIAL  = 4'h0;
    localparam logic [3:0] S_PREPARA  = 4'h1;
    localparam logic [3:0] S_ESPERA   = 4'h2;
    localparam logic [3:0] S_REGISTRA = 4'h4;
    localparam logic [3:0] S_COMPARA  = 4'h5;
    localparam logic [3:0] S_PROXIMO  = 4'h6;
    localparam logic [3:0] S_ACERTO   = 4'hA;
    localparam logic [3:0] S_TIMEOUT  = 4'hD;
    localparam logic [3:0] S_ERRO     = 4'hE;

    localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;

    logic [3:0]         estado;
    logic [3:0]         prox;
    logic [ADDR_W-1:0]  contador;
    logic [WIDTH-1:0]   registro;
    logic [TIMER_W-1:0] timer;
    logic               iniciar_ant;
    logic               jogada_ant;
    logic               iniciar_borda;
    logic               jogada_borda;
    logic               igual;
    logic               expirou;
    logic               fim;

    // History flops reset high so a level held through reset is not an edge.
    assign iniciar_borda = iniciar & ~iniciar_ant;
    assign jogada_borda  = jogada & ~jogada_ant;

    assign igual   = (registro == mem_dado);
    assign expirou = (TIMEOUT != 0) && (timer == TIMER_LAST);
    assign fim     = (estado == S_ACERTO) || (estado == S_ERRO) ||
                     (estado == S_TIMEOUT);

    always_comb begin
        prox = S_INICIAL;
        case (estado)
            S_INICIAL:  prox = iniciar_borda ? S_PREPARA : S_INICIAL;
            S_PREPARA:  prox = S_ESPERA;
            S_ESPERA: begin
                // A play arriving on the expiry cycle takes precedence.
                if (jogada_borda)
                    prox = S_REGISTRA;
                else if (expirou)
                    prox = S_TIMEOUT;
                else
                    prox = S_ESPERA;
            end
            S_REGISTRA: prox = S_COMPARA;
            S_COMPARA: begin
                if (!igual)
                    prox = S_ERRO;
                else if (contador == ADDR_LAST)
                    prox = S_ACERTO;
                else
                    prox = S_PROXIMO;
            end
            S_PROXIMO:  prox = S_ESPERA;
            S_ACERTO,
            S_ERRO,
            S_TIMEOUT:  prox = iniciar_borda ? S_PREPARA : estado;
            default:    prox = S_INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado      <= S_INICIAL;
            contador    <= '0;
            registro    <= '0;
            timer       <= '0;
            iniciar_ant <= 1'b1;
            jogada_ant  <= 1'b1;
        end else begin
            iniciar_ant <= iniciar;
            jogada_ant  <= jogada;
            estado      <= prox;
            case (estado)
                S_PREPARA: begin
                    contador <= '0;
                    registro <= '0;
                    timer    <= '0;
                end
                S_ESPERA: begin
                    if (timer != TIMER_MAX)
                        timer <= timer + TIMER_W'(1);
                end
                S_REGISTRA: registro <= chaves;
                S_PROXIMO: begin
                    if (contador != ADDR_LAST)
                        contador <= contador + ADDR_W'(1);
                    timer <= '0;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr    = contador;
    assign pronto      = fim;
    assign acertou     = (estado == S_ACERTO);
    assign errou       = (estado == S_ERRO);
    assign timeout     = (estado == S_TIMEOUT);
    assign db_contagem = contador;
    assign db_chaves   = registro;
    assign db_memoria  = mem_dado;
    assign db_igual    = igual;
    assign db_estado   = estado;

endmodule

// File: tb/tb_comparador_sequencia.sv
// Self-checking bench for comparador_sequencia.
// Directed scenarios plus randomized plays scored against a sequence model.
module tb_comparador_sequencia;

    localparam int WIDTH   = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 20;
    localparam int ADDR_W  = 2;

    logic              clock;
    logic              reset;
    logic              iniciar;
    logic              jogada;
    logic [WIDTH-1:0]  chaves;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_dado;
    logic              pronto;
    logic              acertou;
    logic              errou;
    logic              timeout;
    logic [ADDR_W-1:0] db_contagem;
    logic [WIDTH-1:0]  db_chaves;
    logic [WIDTH-1:0]  db_memoria;
    logic              db_igual;
    logic [3:0]        db_estado;

    logic [WIDTH-1:0] mem   [DEPTH];
    logic [WIDTH-1:0] plays [DEPTH];

    int n_checks;
    int n_fail;

    assign mem_dado = mem[mem_addr];

    comparador_sequencia #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .iniciar    (iniciar),
        .jogada     (jogada),
        .chaves     (chaves),
        .mem_addr   (mem_addr),
        .mem_dado   (mem_dado),
        .pronto     (pronto),
        .acertou    (acertou),
        .errou      (errou),
        .timeout    (timeout),
        .db_contagem(db_contagem),
        .db_chaves  (db_chaves),
        .db_memoria (db_memoria),
        .db_igual   (db_igual),
        .db_estado  (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start();
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        step();
    endtask

    // Leaves the DUT in the result/PROXIMO state (3 clocks after the edge).
    task automatic jogar(input logic [WIDTH-1:0] v);
        chaves = v;
        jogada = 1'b1;
        step();
        jogada = 1'b0;
        step();
        step();
    endtask

    task automatic load_mem(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
        mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
    endtask

    // Reference: index of first mismatching play, or DEPTH if all match.
    function automatic int primeiro_erro();
        for (int i = 0; i < DEPTH; i++)
            if (plays[i] != mem[i]) return i;
        return DEPTH;
    endfunction

    task automatic test_reset();
        reset = 1'b0; iniciar = 1'b1; jogada = 1'b0; chaves = '0;
        repeat (3) step();
        reset = 1'b1;
        repeat (3) step();
        n_checks++;
        if (db_estado !== 4'h0 || {pronto, acertou, errou, timeout} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_hold: estado=%h flags=%b expected estado=0 flags=0000",
                     db_estado, {pronto, acertou, errou, timeout});
        end
        iniciar = 1'b0;
        step();
        iniciar = 1'b1;
        step();
        n_checks++;
        if (db_estado !== 4'h1) begin
            n_fail++;
            $display("FAIL reset_prepara: estado=%h expected=1", db_estado);
        end
        iniciar = 1'b0;
        step();
        n_checks++;
        if (db_estado !== 4'h2 || db_contagem !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_espera: estado=%h cont=%0d expected 2/0",
                     db_estado, db_contagem);
        end
        repeat (TIMEOUT) step();
        n_checks++;
        if (db_estado !== 4'hD || timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_timeout: estado=%h timeout=%b expected D/1",
                     db_estado, timeout);
        end
    endtask

    task automatic test_acerto();
        load_mem(4'd1, 4'd2, 4'd4, 4'd8);
        start();
        jogar(4'd1); step();
        jogar(4'd2); step();
        jogar(4'd4); step();
        chaves = 4'd8;
        jogada = 1'b1;
        step();
        jogada = 1'b0;
        step();
        n_checks++;
        if (acertou !== 1'b0 || pronto !== 1'b0) begin
            n_fail++;
            $display("FAIL acerto_early: acertou=%b pronto=%b expected 0/0",
                     acertou, pronto);
        end
        step();
        n_checks++;
        if (acertou !== 1'b1 || pronto !== 1'b1 || errou !== 1'b0 ||
            db_estado !== 4'hA || db_contagem !== 2'd3) begin
            n_fail++;
            $display("FAIL acerto: acertou=%b pronto=%b errou=%b estado=%h cont=%0d expected 1/1/0/A/3",
                     acertou, pronto, errou, db_estado, db_contagem);
        end
    endtask

    task automatic test_erro();
        load_mem(4'd1, 4'd2, 4'd4, 4'd8);
        start();
        jogar(4'd1); step();
        jogar(4'd2); step();
        jogar(4'd7);
        n_checks++;
        if (errou !== 1'b1 || db_estado !== 4'hE || db_contagem !== 2'd2 ||
            db_chaves !== 4'd7 || db_memoria !== 4'd4 || db_igual !== 1'b0) begin
            n_fail++;
            $display("FAIL erro: errou=%b estado=%h cont=%0d chaves=%0d mem=%0d igual=%b expected 1/E/2/7/4/0",
                     errou, db_estado, db_contagem, db_chaves, db_memoria, db_igual);
        end
    endtask

    task automatic test_timeout();
        load_mem(4'd1, 4'd2, 4'd4, 4'd8);
        start();
        repeat (TIMEOUT - 1) step();
        n_checks++;
        if (db_estado !== 4'h2 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: estado=%h timeout=%b expected 2/0",
                     db_estado, timeout);
        end
        step();
        n_checks++;
        if (db_estado !== 4'hD || timeout !== 1'b1 || pronto !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_exact: estado=%h timeout=%b pronto=%b expected D/1/1",
                     db_estado, timeout, pronto);
        end
        start();
        repeat (TIMEOUT - 1) step();
        chaves = 4'd1;
        jogada = 1'b1;
        step();
        n_checks++;
        if (db_estado !== 4'h4 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_jogada_wins: estado=%h timeout=%b expected 4/0",
                     db_estado, timeout);
        end
        jogada = 1'b0;
        step();
        step();
        n_checks++;
        if (db_estado !== 4'h6) begin
            n_fail++;
            $display("FAIL timeout_proximo: estado=%h expected=6", db_estado);
        end
        repeat (TIMEOUT + 5) step();
        n_checks++;
        if (db_estado !== 4'hD || db_contagem !== 2'd1) begin
            n_fail++;
            $display("FAIL timeout_second: estado=%h cont=%0d expected D/1",
                     db_estado, db_contagem);
        end
    endtask

    task automatic test_jogada_held();
        load_mem(4'd1, 4'd2, 4'd4, 4'd8);
        start();
        chaves = 4'd1;
        jogada = 1'b1;
        repeat (4) step();
        n_checks++;
        if (db_estado !== 4'h2 || db_contagem !== 2'd1) begin
            n_fail++;
            $display("FAIL held_one_play: estado=%h cont=%0d expected 2/1",
                     db_estado, db_contagem);
        end
        // A second consumed play (1 vs mem[1]=2) would end in ERRO instead.
        repeat (46) step();
        n_checks++;
        if (db_estado !== 4'hD || db_contagem !== 2'd1 || errou !== 1'b0) begin
            n_fail++;
            $display("FAIL held_no_repeat: estado=%h cont=%0d errou=%b expected D/1/0",
                     db_estado, db_contagem, errou);
        end
        jogada = 1'b0;
        step();
    endtask

    task automatic test_restart_and_async_reset();
        load_mem(4'd1, 4'd2, 4'd4, 4'd8);
        start();
        jogar(4'd3);
        n_checks++;
        if (db_estado !== 4'hE) begin
            n_fail++;
            $display("FAIL restart_erro: estado=%h expected=E", db_estado);
        end
        iniciar = 1'b1;
        step();
        n_checks++;
        if (db_estado !== 4'h1) begin
            n_fail++;
            $display("FAIL restart_prepara: estado=%h expected=1", db_estado);
        end
        iniciar = 1'b0;
        step();
        n_checks++;
        if (db_estado !== 4'h2 || db_contagem !== 2'd0 ||
            {pronto, acertou, errou, timeout} !== 4'b0) begin
            n_fail++;
            $display("FAIL restart_espera: estado=%h cont=%0d flags=%b expected 2/0/0000",
                     db_estado, db_contagem, {pronto, acertou, errou, timeout});
        end
        jogar(4'd1); step();
        jogar(4'd2); step();
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        step();
        n_checks++;
        if (db_estado !== 4'h2 || db_contagem !== 2'd2) begin
            n_fail++;
            $display("FAIL iniciar_ignored: estado=%h cont=%0d expected 2/2",
                     db_estado, db_contagem);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (db_estado !== 4'h0 || db_contagem !== 2'd0 ||
            {pronto, acertou, errou, timeout} !== 4'b0) begin
            n_fail++;
            $display("FAIL async_reset: estado=%h cont=%0d flags=%b expected 0/0/0000",
                     db_estado, db_contagem, {pronto, acertou, errou, timeout});
        end
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_random();
        int e;
        int n;
        int gap;
        for (int it = 0; it < 25; it++) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] = WIDTH'($urandom);
                plays[k] = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : mem[k];
            end
            e = primeiro_erro();
            n = (e < DEPTH) ? e + 1 : DEPTH;
            start();
            for (int i = 0; i < n; i++) begin
                gap = $urandom_range(0, 4);
                repeat (gap) step();
                jogar(plays[i]);
                if (i < n - 1) begin
                    step();
                    n_checks++;
                    if (db_estado !== 4'h2 || db_contagem !== ADDR_W'(i + 1)) begin
                        n_fail++;
                        $display("FAIL rand_mid it=%0d i=%0d: estado=%h cont=%0d expected 2/%0d",
                                 it, i, db_estado, db_contagem, i + 1);
                    end
                end
            end
            n_checks++;
            if (pronto !== 1'b1 || acertou !== (e == DEPTH) || errou !== (e < DEPTH) ||
                db_contagem !== ADDR_W'(n - 1) || db_chaves !== plays[n - 1] ||
                db_igual !== (e == DEPTH)) begin
                n_fail++;
                $display("FAIL rand_end it=%0d: pronto=%b ac=%b er=%b cont=%0d ch=%0d ig=%b expected 1/%0d/%0d/%0d/%0d/%0d",
                         it, pronto, acertou, errou, db_contagem, db_chaves, db_igual,
                         (e == DEPTH), (e < DEPTH), n - 1, plays[n - 1], (e == DEPTH));
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int k = 0; k < DEPTH; k++) mem[k] = '0;
        test_reset();
        test_acerto();
        test_erro();
        test_timeout();
        test_jogada_held();
        test_restart_and_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
